sync_digit_counter: RTL

SYNC_DIGIT_COUNTER -- requirements
Module: sync_digit_counter

---
 rtl/sync_digit_counter.sv | 89 ++++++++
 1 files changed

// File: rtl/sync_digit_counter.sv
// Cascaded modulo-MOD digit counter stepped by a DIV-cycle prescaler on clk.
// Define SYNC_DIGIT_COUNTER_DOWN_EN to add the dir input for down counting.
module sync_digit_counter #(
  parameter int DIGITS = 4,
  parameter int W      = 4,
  parameter int MOD    = 10,
  parameter int DIV    = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
`ifdef SYNC_DIGIT_COUNTER_DOWN_EN
  input  logic                dir,
`endif
  input  logic                clr,
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_val,
  output logic [DIGITS*W-1:0] digits,
  output logic                tick,
  output logic                carry
);

  localparam int            PW       = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [W-1:0]  DIG_MAX  = W'(MOD - 1);

  logic [PW-1:0]            pre;
  logic [DIGITS-1:0][W-1:0] cnt;
  logic [DIGITS-1:0][W-1:0] cnt_step;
  logic [DIGITS-1:0][W-1:0] cnt_load;
  logic                     wrap;
  logic                     step;
  logic                     down;

`ifdef SYNC_DIGIT_COUNTER_DOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  assign step = en && (pre == PRE_LAST);

  // wrap tracks "every digit below i sits at its roll-over value"
  always_comb begin
    cnt_step = cnt;
    wrap     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (wrap) begin
        if (down) cnt_step[i] = (cnt[i] == '0) ? DIG_MAX : cnt[i] - 1'b1;
        else      cnt_step[i] = (cnt[i] == DIG_MAX) ? '0 : cnt[i] + 1'b1;
      end
      wrap = wrap & (down ? (cnt[i] == '0) : (cnt[i] == DIG_MAX));
    end
  end

  // out-of-range load digits are forced to zero
  always_comb begin
    cnt_load = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(load_val[i*W +: W]) < MOD) cnt_load[i] = load_val[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre   <= '0;
      cnt   <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else if (clr) begin
      pre   <= '0;
      cnt   <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else if (load) begin
      cnt   <= cnt_load;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      tick  <= step;
      carry <= step & wrap;
      if (en) pre <= step ? '0 : pre + 1'b1;
      if (step) cnt <= cnt_step;
    end
  end

  assign digits = cnt;

endmodule
